// File: rtl/issue_queue_if.sv
// ---------------------------------------------------------------------------
// issue_queue_if -- dispatch, CDB and issue bundle of the issue queue.
//
//   master : the pipeline side. It drives dispatch, CDB broadcasts and
//            issue_ready, and observes full and the issue_* outputs.
//   slave  : the issue queue itself.
//
//   disp_*   dispatch request: op, ROB dest tag, operand values and, per
//            operand, the producer tag and its pending flag
//   full     no free entry (registered)
//   issue_*  registered issue slot toward the ALU, plus issue_ready back
//   cdb_*    NCDB broadcast ports, packed, with port k at slice k
// ---------------------------------------------------------------------------
interface issue_queue_if #(
  parameter int TAG_W = 4,
  parameter int NCDB  = 2,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6
);
  logic                 disp_valid;
  logic [OP_W-1:0]      disp_op;
  logic [TAG_W-1:0]     disp_dest;
  logic [XLEN-1:0]      disp_vj;
  logic [XLEN-1:0]      disp_vk;
  logic [TAG_W-1:0]     disp_qj;
  logic [TAG_W-1:0]     disp_qk;
  logic                 disp_qj_busy;
  logic                 disp_qk_busy;
  logic                 full;

  logic                 issue_ready;
  logic                 issue_valid;
  logic [OP_W-1:0]      issue_op;
  logic [XLEN-1:0]      issue_src1;
  logic [XLEN-1:0]      issue_src2;
  logic [TAG_W-1:0]     issue_dest;

  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_val;

  modport master (
    output disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
           disp_qj, disp_qk, disp_qj_busy, disp_qk_busy,
           issue_ready, cdb_valid, cdb_tag, cdb_val,
    input  full, issue_valid, issue_op, issue_src1, issue_src2, issue_dest
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest, disp_vj, disp_vk,
           disp_qj, disp_qk, disp_qj_busy, disp_qk_busy,
           issue_ready, cdb_valid, cdb_tag, cdb_val,
    output full, issue_valid, issue_op, issue_src1, issue_src2, issue_dest
  );
endinterface

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue -- out-of-order issue queue (reservation station).
//
// An instruction is dispatched into the lowest-index free entry. Pending
// operands capture their value from the CDB, both at dispatch (bypass) and
// while they wait in the queue. Each cycle the oldest entry whose operands
// are both available is sent to the ALU through registered issue_* outputs.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   rdy    global enable; low freezes every register
//   clear  pipeline flush; empties the queue
//   bus    issue_queue_if.slave (dispatch, CDB, issue, full)
//
// Age: every valid entry holds a rank equal to the number of older valid
// entries. The newest entry gets rank = occupancy, and issuing an entry
// decrements the ranks above it. Ranks are therefore always dense in
// 0..count-1, so there is no sequence counter that can wrap and corrupt
// the ordering.
// ---------------------------------------------------------------------------
module issue_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int NCDB  = 2,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  issue_queue_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // control state
  logic [DEPTH-1:0] valid_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             issue_valid_reg;

  // entry payload (not reset)
  logic [DEPTH-1:0] qj_busy_reg;
  logic [DEPTH-1:0] qk_busy_reg;
  logic [OP_W-1:0]  op_reg   [DEPTH];
  logic [TAG_W-1:0] dest_reg [DEPTH];
  logic [XLEN-1:0]  vj_reg   [DEPTH];
  logic [XLEN-1:0]  vk_reg   [DEPTH];
  logic [TAG_W-1:0] qj_reg   [DEPTH];
  logic [TAG_W-1:0] qk_reg   [DEPTH];
  logic [IW-1:0]    rank_reg [DEPTH];

  logic [OP_W-1:0]  issue_op_reg;
  logic [XLEN-1:0]  issue_src1_reg;
  logic [XLEN-1:0]  issue_src2_reg;
  logic [TAG_W-1:0] issue_dest_reg;

  // per-entry wakeup and readiness
  logic [DEPTH-1:0] wake_j;
  logic [DEPTH-1:0] wake_k;
  logic [XLEN-1:0]  wake_j_val [DEPTH];
  logic [XLEN-1:0]  wake_k_val [DEPTH];
  logic [DEPTH-1:0] ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic            j_hit;
    logic            k_hit;
    logic [XLEN-1:0] j_val;
    logic [XLEN-1:0] k_val;

    // Scan from the highest port down, so the lowest matching port wins.
    always_comb begin
      j_hit = 1'b0;
      k_hit = 1'b0;
      j_val = '0;
      k_val = '0;
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == qj_reg[gi]) begin
          j_hit = 1'b1;
          j_val = bus.cdb_val[k*XLEN +: XLEN];
        end
        if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == qk_reg[gi]) begin
          k_hit = 1'b1;
          k_val = bus.cdb_val[k*XLEN +: XLEN];
        end
      end
    end

    assign wake_j[gi]     = j_hit;
    assign wake_k[gi]     = k_hit;
    assign wake_j_val[gi] = j_val;
    assign wake_k_val[gi] = k_val;
    // Readiness comes from registered flags only, so a broadcast becomes
    // visible to selection one cycle later.
    assign ready[gi]      = valid_reg[gi] & ~qj_busy_reg[gi] & ~qk_busy_reg[gi];
  end

  // Dispatch bypass: an operand whose producer broadcasts this very cycle.
  logic            disp_j_busy;
  logic            disp_k_busy;
  logic [XLEN-1:0] disp_j_val;
  logic [XLEN-1:0] disp_k_val;

  always_comb begin
    disp_j_busy = bus.disp_qj_busy;
    disp_k_busy = bus.disp_qk_busy;
    disp_j_val  = bus.disp_vj;
    disp_k_val  = bus.disp_vk;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (bus.disp_qj_busy && bus.cdb_valid[k] &&
          bus.cdb_tag[k*TAG_W +: TAG_W] == bus.disp_qj) begin
        disp_j_busy = 1'b0;
        disp_j_val  = bus.cdb_val[k*XLEN +: XLEN];
      end
      if (bus.disp_qk_busy && bus.cdb_valid[k] &&
          bus.cdb_tag[k*TAG_W +: TAG_W] == bus.disp_qk) begin
        disp_k_busy = 1'b0;
        disp_k_val  = bus.cdb_val[k*XLEN +: XLEN];
      end
    end
  end

  // Oldest ready entry (lowest rank) and lowest-index free entry.
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] sel_rank;
  logic          free_found;
  logic [IW-1:0] free_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || rank_reg[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_rank  = rank_reg[i];
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // A slot being freed by this cycle's issue is still valid here, so it
  // cannot be reused until the next cycle.
  logic          do_issue;
  logic          accept;
  logic [IW-1:0] new_rank;

  assign do_issue = bus.issue_ready && sel_found;
  assign accept   = bus.disp_valid && !full_reg && free_found;
  assign new_rank = do_issue ? IW'(count_reg - CW'(1)) : IW'(count_reg);

  always_comb begin
    count_next = count_reg;
    if (accept && !do_issue) begin
      count_next = count_reg + CW'(1);
    end else if (!accept && do_issue) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_reg       <= '0;
      count_reg       <= '0;
      full_reg        <= 1'b0;
      issue_valid_reg <= 1'b0;
    end else if (rdy) begin
      count_reg       <= count_next;
      full_reg        <= (count_next == CW'(DEPTH));
      issue_valid_reg <= do_issue;
      if (do_issue) begin
        valid_reg[sel_idx] <= 1'b0;
      end
      if (accept) begin
        valid_reg[free_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_reg[i] && qj_busy_reg[i] && wake_j[i]) begin
          vj_reg[i]      <= wake_j_val[i];
          qj_busy_reg[i] <= 1'b0;
        end
        if (valid_reg[i] && qk_busy_reg[i] && wake_k[i]) begin
          vk_reg[i]      <= wake_k_val[i];
          qk_busy_reg[i] <= 1'b0;
        end
        if (do_issue && valid_reg[i] && rank_reg[i] > sel_rank) begin
          rank_reg[i] <= rank_reg[i] - IW'(1);
        end
      end
      if (accept) begin
        op_reg[free_idx]      <= bus.disp_op;
        dest_reg[free_idx]    <= bus.disp_dest;
        vj_reg[free_idx]      <= disp_j_val;
        vk_reg[free_idx]      <= disp_k_val;
        qj_reg[free_idx]      <= bus.disp_qj;
        qk_reg[free_idx]      <= bus.disp_qk;
        qj_busy_reg[free_idx] <= disp_j_busy;
        qk_busy_reg[free_idx] <= disp_k_busy;
        rank_reg[free_idx]    <= new_rank;
      end
      if (do_issue) begin
        issue_op_reg   <= op_reg[sel_idx];
        issue_src1_reg <= vj_reg[sel_idx];
        issue_src2_reg <= vk_reg[sel_idx];
        issue_dest_reg <= dest_reg[sel_idx];
      end
    end
  end

  assign bus.full        = full_reg;
  assign bus.issue_valid = issue_valid_reg;
  assign bus.issue_op    = issue_op_reg;
  assign bus.issue_src1  = issue_src1_reg;
  assign bus.issue_src2  = issue_src2_reg;
  assign bus.issue_dest  = issue_dest_reg;
endmodule

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_issue_queue -- directed stimulus with a scoreboard for issue_queue.
// Stimulus pushes each hand-computed issue record in the order the queue
// must issue it. A monitor on the falling edge pops and compares every
// freshly registered issue. Flag checks (full, issue_valid) are made
// inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_issue_queue;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int NCDB  = 2;
  localparam int XLEN  = 32;
  localparam int OP_W  = 6;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;
  logic upd = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  issue_queue_if #(.TAG_W(TAG_W), .NCDB(NCDB), .XLEN(XLEN), .OP_W(OP_W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB), .XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // The issue registers change only on an edge where the queue was enabled
  // and not being flushed.
  always @(posedge clk) upd <= rdy && !rst && !clear;

  always @(negedge clk) begin
    if (upd && bus.issue_valid) begin
      exp_t got;
      exp_t e;
      got = '{op: bus.issue_op, src1: bus.issue_src1, src2: bus.issue_src2, dest: bus.issue_dest};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got op=%0h src1=%0h src2=%0h dest=%0h, required no issue",
                 got.op, got.src1, got.src2, got.dest);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL issue: got op=%0h src1=%0h src2=%0h dest=%0h, required op=%0h src1=%0h src2=%0h dest=%0h",
                   got.op, got.src1, got.src2, got.dest, e.op, e.src1, e.src2, e.dest);
        end else begin
          $display("issue ok: op=%0h src1=%0h src2=%0h dest=%0h", got.op, got.src1, got.src2, got.dest);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [XLEN-1:0] s1,
                      input logic [XLEN-1:0] s2, input logic [TAG_W-1:0] dest);
    exp_q.push_back('{op: op, src1: s1, src2: s2, dest: dest});
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                      input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                      input logic [TAG_W-1:0] qj, input logic qjb,
                      input logic [TAG_W-1:0] qk, input logic qkb);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_dest    = dest;
    bus.disp_vj      = vj;
    bus.disp_vk      = vk;
    bus.disp_qj      = qj;
    bus.disp_qk      = qk;
    bus.disp_qj_busy = qjb;
    bus.disp_qk_busy = qkb;
  endtask

  task automatic cdb(input logic [1:0] v, input logic [TAG_W-1:0] t0, input logic [XLEN-1:0] d0,
                     input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] d1);
    bus.cdb_valid = v;
    bus.cdb_tag   = {t1, t0};
    bus.cdb_val   = {d1, d0};
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = '0;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    clear = 1'b0;
    bus.issue_ready = 1'b0;
    disp(0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    cdb(2'b00, 0, 0, 0, 0);
    idle();
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset_full", 64'(bus.full), 64'd0);
    chk("reset_issue_valid", 64'(bus.issue_valid), 64'd0);

    // Ready dispatch: issues the next cycle, then the slot goes quiet.
    bus.issue_ready = 1'b1;
    disp(6'h05, 4'd1, 32'd3, 32'd4, 0, 1'b0, 0, 1'b0);
    push(6'h05, 32'd3, 32'd4, 4'd1);
    cyc();
    idle();
    cyc();
    chk("ready_issue_valid", 64'(bus.issue_valid), 64'd1);
    cyc();
    chk("ready_then_idle", 64'(bus.issue_valid), 64'd0);

    // Age ordering: A waits on tag 2, B and C are ready.
    disp(6'h01, 4'd2, 32'd0, 32'd5, 4'd2, 1'b1, 0, 1'b0);
    cyc();
    disp(6'h02, 4'd3, 32'd10, 32'd11, 0, 1'b0, 0, 1'b0);
    push(6'h02, 32'd10, 32'd11, 4'd3);
    cyc();
    disp(6'h03, 4'd4, 32'd12, 32'd13, 0, 1'b0, 0, 1'b0);
    push(6'h03, 32'd12, 32'd13, 4'd4);
    cyc();
    idle();
    cdb(2'b01, 4'd2, 32'd9, 4'd0, 32'd0);
    push(6'h01, 32'd9, 32'd5, 4'd2);
    cyc();
    idle();
    repeat (3) cyc();

    // Oldest entry sits in a higher slot than a younger ready one.
    bus.issue_ready = 1'b0;
    disp(6'h10, 4'd5, 32'd1, 32'd2, 0, 1'b0, 0, 1'b0);
    push(6'h10, 32'd1, 32'd2, 4'd5);
    cyc();
    disp(6'h11, 4'd6, 32'd0, 32'd3, 4'd6, 1'b1, 0, 1'b0);
    cyc();
    idle();
    bus.issue_ready = 1'b1;
    cyc();
    bus.issue_ready = 1'b0;
    disp(6'h12, 4'd7, 32'd4, 32'd5, 0, 1'b0, 0, 1'b0);
    cyc();
    idle();
    cdb(2'b10, 4'd0, 32'd0, 4'd6, 32'h66);
    push(6'h11, 32'h66, 32'd3, 4'd6);
    push(6'h12, 32'd4, 32'd5, 4'd7);
    cyc();
    idle();
    bus.issue_ready = 1'b1;
    repeat (4) cyc();

    // Dispatch bypass on port 1; port 0 carries the same tag but is invalid.
    disp(6'h07, 4'd8, 32'd0, 32'h22, 4'd7, 1'b1, 0, 1'b0);
    cdb(2'b10, 4'd7, 32'hBB, 4'd7, 32'hAA);
    push(6'h07, 32'hAA, 32'h22, 4'd8);
    cyc();
    idle();
    cyc();
    chk("bypass_issue_valid", 64'(bus.issue_valid), 64'd1);
    cyc();

    // Both ports match a waiting operand: port 0 wins.
    disp(6'h08, 4'd9, 32'd1, 32'd0, 0, 1'b0, 4'd8, 1'b1);
    cyc();
    idle();
    cdb(2'b11, 4'd8, 32'h11, 4'd8, 32'h22);
    push(6'h08, 32'd1, 32'h11, 4'd9);
    cyc();
    idle();
    repeat (3) cyc();

    // Full boundary.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_W'(i), TAG_W'(i), XLEN'(i), XLEN'(100 + i), 0, 1'b0, 0, 1'b0);
      push(OP_W'(i), XLEN'(i), XLEN'(100 + i), TAG_W'(i));
      cyc();
      if (i == DEPTH - 2) chk("full_at_15", 64'(bus.full), 64'd0);
    end
    chk("full_at_16", 64'(bus.full), 64'd1);
    disp(6'h3F, 4'd15, 32'h3F, 32'h3F, 0, 1'b0, 0, 1'b0);
    cyc();
    chk("full_17th_dropped", 64'(bus.full), 64'd1);
    bus.issue_ready = 1'b1;
    disp(6'h30, 4'd0, 32'h30, 32'h130, 0, 1'b0, 0, 1'b0);
    cyc();
    chk("full_issue_drops_disp", 64'(bus.full), 64'd0);
    disp(6'h31, 4'd1, 32'h31, 32'h131, 0, 1'b0, 0, 1'b0);
    push(6'h31, 32'h31, 32'h131, 4'd1);
    cyc();
    chk("full_disp_and_issue", 64'(bus.full), 64'd0);
    bus.issue_ready = 1'b0;
    disp(6'h32, 4'd2, 32'h32, 32'h132, 0, 1'b0, 0, 1'b0);
    push(6'h32, 32'h32, 32'h132, 4'd2);
    cyc();
    chk("full_after_refill", 64'(bus.full), 64'd1);
    idle();
    bus.issue_ready = 1'b1;
    repeat (20) cyc();
    chk("full_after_drain", 64'(bus.full), 64'd0);

    // Stall: issue registers hold, dispatch and CDB are ignored.
    disp(6'h15, 4'd10, 32'h50, 32'h51, 0, 1'b0, 0, 1'b0);
    push(6'h15, 32'h50, 32'h51, 4'd10);
    cyc();
    idle();
    cyc();
    rdy = 1'b0;
    disp(6'h3E, 4'd11, 32'h60, 32'h61, 0, 1'b0, 0, 1'b0);
    cdb(2'b01, 4'd3, 32'h77, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold_valid", 64'(bus.issue_valid), 64'd1);
      chk("stall_hold_op", 64'(bus.issue_op), 64'h15);
    end
    idle();
    rdy = 1'b1;
    cyc();
    chk("stall_resume_idle", 64'(bus.issue_valid), 64'd0);
    repeat (3) cyc();

    // Flush with 5 entries, racing a dispatch, wakeup and issue.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(OP_W'(32 + i), TAG_W'(i), XLEN'(i), XLEN'(i), 0, 1'b0, 0, 1'b0);
      cyc();
    end
    clear = 1'b1;
    bus.issue_ready = 1'b1;
    disp(6'h3D, 4'd12, 32'd1, 32'd1, 0, 1'b0, 0, 1'b0);
    cdb(2'b01, 4'd1, 32'd1, 4'd0, 32'd0);
    cyc();
    clear = 1'b0;
    idle();
    chk("clear_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("clear_full", 64'(bus.full), 64'd0);

    // Count restarted from zero: exactly 16 more dispatches fill the queue.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_W'(i), TAG_W'(i), XLEN'(i), XLEN'(i), 0, 1'b0, 0, 1'b0);
      cyc();
      if (i == DEPTH - 2) chk("clear_refill_15", 64'(bus.full), 64'd0);
    end
    chk("clear_refill_16", 64'(bus.full), 64'd1);
    idle();
    rdy = 1'b0;
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold_full", 64'(bus.full), 64'd1);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    rdy = 1'b1;
    chk("clear_while_stalled_full", 64'(bus.full), 64'd0);
    chk("clear_while_stalled_valid", 64'(bus.issue_valid), 64'd0);
    repeat (4) cyc();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
